// File: rtl/datapath_run_ctrl.sv
// Run/step/halt sequencer: issues one-Clk CpuEn pulses to advance the datapath.
// Optional PC breakpoint stop is built when PC_BREAKPOINT_EN is defined.
module datapath_run_ctrl #(
   parameter int DIV_COUNT  = 50000000,
   parameter int RST_CYCLES = 4,
   parameter int PC_WIDTH   = 32
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                RunBtn,
   input  logic                StepBtn,
   input  logic                HaltBtn,
   input  logic [PC_WIDTH-1:0] PC,
   input  logic [PC_WIDTH-1:0] BreakAddr,
   input  logic                BreakValid,
   output logic                CpuEn,
   output logic                DpReset,
   output logic                Halted,
   output logic                BreakHit,
   output logic [1:0]          State,
   output logic [31:0]         CycleCount
);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_HALT = 2'd1,
      S_RUN  = 2'd2,
      S_STEP = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic        cpu_en, cpu_en_nxt;
   logic        dp_reset, dp_reset_nxt;
   logic        halted, halted_nxt;
   logic [31:0] cycle_count, cycle_count_nxt;
   logic [31:0] div_cnt, div_cnt_nxt;
   logic [31:0] init_cnt, init_cnt_nxt;

`ifdef PC_BREAKPOINT_EN
   logic brk_mask, brk_mask_nxt;
   logic break_hit, break_hit_nxt;
   logic bp_match;

   // Masked until the first pulse after RunBtn so a restart from the breakpoint moves on.
   assign bp_match = BreakValid && (PC == BreakAddr) && !brk_mask;
`else
   logic unused_bp;
   assign unused_bp = ^{PC, BreakAddr, BreakValid};
`endif

   always_comb begin
      state_nxt     = state;
      cpu_en_nxt    = 1'b0;
      dp_reset_nxt  = dp_reset;
      halted_nxt    = halted;
      div_cnt_nxt   = div_cnt;
      init_cnt_nxt  = init_cnt;
`ifdef PC_BREAKPOINT_EN
      brk_mask_nxt  = brk_mask;
      break_hit_nxt = break_hit;
`endif
      unique case (state)
         S_INIT: begin
            init_cnt_nxt = init_cnt + 32'd1;
            if (init_cnt == 32'(RST_CYCLES - 1)) begin
               dp_reset_nxt = 1'b0;
               halted_nxt   = 1'b1;
               state_nxt    = S_HALT;
            end
         end
         S_HALT: begin
            if (!HaltBtn) begin
               if (StepBtn) begin
                  state_nxt  = S_STEP;
                  cpu_en_nxt = 1'b1;
`ifdef PC_BREAKPOINT_EN
                  break_hit_nxt = 1'b0;
`endif
               end else if (RunBtn) begin
                  state_nxt   = S_RUN;
                  halted_nxt  = 1'b0;
                  div_cnt_nxt = '0;
`ifdef PC_BREAKPOINT_EN
                  brk_mask_nxt  = 1'b1;
                  break_hit_nxt = 1'b0;
`endif
               end
            end
         end
         S_STEP: begin
            state_nxt = S_HALT;
         end
         S_RUN: begin
            // Any stop wins over a pulse falling due on the same edge.
            if (HaltBtn) begin
               state_nxt   = S_HALT;
               halted_nxt  = 1'b1;
               div_cnt_nxt = '0;
            end
`ifdef PC_BREAKPOINT_EN
            else if (bp_match) begin
               state_nxt     = S_HALT;
               halted_nxt    = 1'b1;
               div_cnt_nxt   = '0;
               break_hit_nxt = 1'b1;
            end
`endif
            else if (div_cnt == 32'(DIV_COUNT - 1)) begin
               div_cnt_nxt = '0;
               cpu_en_nxt  = 1'b1;
`ifdef PC_BREAKPOINT_EN
               brk_mask_nxt = 1'b0;
`endif
            end else begin
               div_cnt_nxt = div_cnt + 32'd1;
            end
         end
      endcase
      cycle_count_nxt = cycle_count + {31'd0, cpu_en_nxt};
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state       <= S_INIT;
         cpu_en      <= 1'b0;
         dp_reset    <= 1'b1;
         halted      <= 1'b0;
         cycle_count <= '0;
         div_cnt     <= '0;
         init_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         cpu_en      <= cpu_en_nxt;
         dp_reset    <= dp_reset_nxt;
         halted      <= halted_nxt;
         cycle_count <= cycle_count_nxt;
         div_cnt     <= div_cnt_nxt;
         init_cnt    <= init_cnt_nxt;
      end
   end

`ifdef PC_BREAKPOINT_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         brk_mask  <= 1'b0;
         break_hit <= 1'b0;
      end else begin
         brk_mask  <= brk_mask_nxt;
         break_hit <= break_hit_nxt;
      end
   end

   assign BreakHit = break_hit;
`else
   assign BreakHit = 1'b0;
`endif

   assign State      = state;
   assign CpuEn      = cpu_en;
   assign DpReset    = dp_reset;
   assign Halted     = halted;
   assign CycleCount = cycle_count;

endmodule

// File: doc/datapath_run_ctrl.md
Name: datapath_run_ctrl

Overview:
Run/step/halt sequencer for the pipelined datapath. Runs on the fast board clock and issues single-cycle clock-enable pulses (CpuEn) that advance the datapath, so it no longer needs a divided clock. Holds the datapath in reset after power-up, supports free-run at a programmable rate, single-step and PC breakpoint, and exposes a retired-cycle count for the 8-digit display.

Parameters:
DIV_COUNT, 50000000, Clk cycles between CpuEn pulses in RUN (must be >= 1)
RST_CYCLES, 4, Clk cycles DpReset is held after Reset release (must be >= 1)
PC_WIDTH, 32, width of PC and BreakAddr

Ports:
Clk  in  1  board clock
Reset  in  1  asynchronous, active-low reset
RunBtn  in  1  one-Clk pulse from the upstream debouncer: start free-run
StepBtn  in  1  one-Clk pulse: advance exactly one datapath cycle
HaltBtn  in  1  one-Clk pulse: stop free-run
PC  in  PC_WIDTH  current datapath PC
BreakAddr  in  PC_WIDTH  breakpoint address
BreakValid  in  1  breakpoint armed
CpuEn  out  1  registered datapath advance enable, one Clk wide
DpReset  out  1  registered, active-high datapath reset
Halted  out  1  high in HALT
BreakHit  out  1  sticky: last stop was caused by the breakpoint
State  out  2  INIT=0, HALT=1, RUN=2, STEP=3
CycleCount  out  32  number of CpuEn pulses issued

Behaviour:
- Reset low (asynchronous): State=INIT, CpuEn=0, DpReset=1, Halted=0, BreakHit=0, CycleCount=0, DivCnt=0, InitCnt=0.
- All outputs are registered. There is no combinational path from input to output.
- INIT: InitCnt counts up by 1 each Clk. At the edge where InitCnt==RST_CYCLES-1: DpReset<=0, Halted<=1, State<=HALT. Buttons are ignored in INIT.
- HALT, priority HaltBtn > StepBtn > RunBtn when pulses coincide:
  - HaltBtn: no change.
  - StepBtn: State<=STEP, CpuEn<=1.
  - RunBtn: State<=RUN, Halted<=0, DivCnt<=0, BrkMask<=1.
  - StepBtn or RunBtn clears BreakHit.
- STEP: lasts exactly one Clk, in which CpuEn=1. Next edge: CpuEn<=0, State<=HALT. Buttons are ignored during STEP.
  - Latency: StepBtn sampled at edge k gives CpuEn high from k to k+1, and State=HALT after k+1.
- RUN:
  - DivCnt increments each Clk. At the edge where DivCnt==DIV_COUNT-1: DivCnt<=0, CpuEn<=1, BrkMask<=0. CpuEn<=0 at all other edges.
  - The first pulse comes DIV_COUNT Clk after entry. DIV_COUNT=1 gives CpuEn high every cycle.
  - HaltBtn: State<=HALT, Halted<=1, CpuEn<=0, DivCnt<=0. A pulse due on that same edge is suppressed.
  - StepBtn and RunBtn are ignored in RUN.
- CycleCount increments on every edge at which CpuEn<=1 is registered. It wraps from 0xFFFFFFFF to 0 and is cleared only by Reset.
- DpReset is high only during reset and INIT.
- Reset asserted mid-RUN or mid-STEP: immediate return to reset values, and the sequence restarts from INIT.

Optional Feature:
Macro PC_BREAKPOINT_EN.
- Defined:
  - In RUN, when BreakValid=1, PC==BreakAddr and BrkMask=0: State<=HALT, Halted<=1, BreakHit<=1, CpuEn<=0, DivCnt<=0.
  - A breakpoint stop has priority over a pulse due on the same edge.
  - BrkMask means that after RunBtn from a breakpoint stop, at least one CpuEn is issued before the breakpoint is re-checked.
  - The breakpoint is not checked in STEP or HALT.
- Undefined:
  - PC, BreakAddr and BreakValid are present but ignored.
  - BreakHit is constant 0 and the BrkMask logic is removed.

Test Plan:
- Reset low then released, RST_CYCLES=4 -> DpReset=1 for 4 Clk after release, then 0; State=1; Halted=1; CycleCount=0.
- In HALT, StepBtn pulse -> CpuEn high for exactly 1 Clk, State 3->1, CycleCount=1; StepBtn and RunBtn in the same cycle -> behaves as step only.
- DIV_COUNT=4, RunBtn, 20 Clk -> CpuEn pulses at Clk 4, 8, 12, 16, 20 after entry, CycleCount=5; then HaltBtn -> CpuEn stays 0, Halted=1.
- DIV_COUNT=4, HaltBtn on the same edge a pulse is due -> no pulse, CycleCount unchanged; DIV_COUNT=1 in RUN -> CpuEn held high every Clk.
- PC_BREAKPOINT_EN, BreakValid=1, BreakAddr=0x10, PC stepping by 4 per CpuEn from 0 -> halt at PC=0x10, BreakHit=1; RunBtn -> one CpuEn issued (PC=0x14) before the breakpoint is re-armed, BreakHit=0.
- CycleCount forced to 0xFFFFFFFF via stepping, or long run with DIV_COUNT=1 -> next CpuEn gives 0; Reset asserted mid-RUN -> CpuEn=0 and DpReset=1 asynchronously.
